// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback stage
package wb_pkg;
   typedef enum logic [0:0] {IDLE, WAIT_MEM} wb_state_e;
   localparam logic [1:0] LD_WORD   = 2'd0;
   localparam logic [1:0] LD_BYTE_S = 2'd1;
   localparam logic [1:0] LD_BYTE_U = 2'd2;
   localparam int SRC_ALU     = 0;
   localparam int SRC_MEM     = 1;
   localparam int SRC_PC_LINK = 2;
   localparam int SRC_IMM     = 3;
endpackage

// File: rtl/wb_if.sv
// wb_if: request, memory-return and register-file write signals of the writeback stage
interface wb_if #(
   parameter int WIDTH      = 16,
   parameter int NUM_SRC    = 4,
   parameter int REG_ADDR_W = 3
);
   logic                         wb_valid;
   logic                         wb_ready;
   logic [$clog2(NUM_SRC)-1:0]   wb_sel;
   logic [REG_ADDR_W-1:0]        wb_rd;
   logic [1:0]                   load_mode;
   logic [NUM_SRC*WIDTH-1:0]     src_data;
   logic [WIDTH-1:0]             mem_rdata;
   logic                         mem_rvalid;
   logic                         rf_we;
   logic [REG_ADDR_W-1:0]        rf_waddr;
   logic [WIDTH-1:0]             rf_wdata;
   logic                         mem_err;
   modport master (
      output wb_valid, wb_sel, wb_rd, load_mode, src_data, mem_rdata, mem_rvalid,
      input  wb_ready, rf_we, rf_waddr, rf_wdata, mem_err
   );
   modport slave (
      input  wb_valid, wb_sel, wb_rd, load_mode, src_data, mem_rdata, mem_rvalid,
      output wb_ready, rf_we, rf_waddr, rf_wdata, mem_err
   );
endinterface

// File: rtl/wb_load_ext.sv
// wb_load_ext: word / signed byte / unsigned byte load extension
module wb_load_ext
   import wb_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH-1:0] data_o
);
   always_comb data_o = mode_i == LD_BYTE_S ? WIDTH'($signed(data_i[7:0])) :
                        mode_i == LD_BYTE_U ? WIDTH'(data_i[7:0]) : data_i;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: source-select writeback with variable-latency load wait and timeout
module wb_stage
   import wb_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int NUM_SRC    = 4,
   parameter int MEM_IDX    = SRC_MEM,
   parameter int REG_ADDR_W = 3,
   parameter bit ZERO_REG   = 1'b1,
   parameter int TIMEOUT    = 15
) (
   input logic clk,
   input logic rst,
   wb_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_SRC);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   wb_state_e             state_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [REG_ADDR_W-1:0] rd_q, waddr_q;
   logic [1:0]            mode_q;
   logic [WIDTH-1:0]      wdata_q, src_val, ext_val;
   logic                  we_q, err_q;
   logic [SEL_W-1:0]      sel;
   logic                  accept, is_load, new_ok, pend_ok;
   wb_load_ext #(.WIDTH(WIDTH)) u_ext (.data_i(bus.mem_rdata), .mode_i(mode_q), .data_o(ext_val));
   always_comb begin
      sel     = int'(bus.wb_sel) < NUM_SRC ? bus.wb_sel : '0;
      src_val = bus.src_data[int'(sel)*WIDTH +: WIDTH];
      is_load = int'(sel) == MEM_IDX;
      accept  = bus.wb_valid && state_q == IDLE;
      new_ok  = !(ZERO_REG && bus.wb_rd == '0);
      pend_ok = !(ZERO_REG && rd_q == '0);
      cnt_d   = cnt_q == CNT_W'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
   end
   // Data returning on the timeout cycle takes priority over the error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
         mode_q  <= LD_WORD;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q  <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE: if (accept && is_load) begin
               rd_q    <= bus.wb_rd;
               mode_q  <= bus.load_mode;
               cnt_q   <= '0;
               state_q <= WAIT_MEM;
            end else if (accept) begin
               we_q    <= new_ok;
               waddr_q <= bus.wb_rd;
               wdata_q <= src_val;
            end
            WAIT_MEM: if (bus.mem_rvalid) begin
               we_q    <= pend_ok;
               waddr_q <= rd_q;
               wdata_q <= ext_val;
               state_q <= IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               err_q   <= 1'b1;
               state_q <= IDLE;
            end else cnt_q <= cnt_d;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.wb_ready = state_q == IDLE;
   assign bus.rf_we    = we_q;
   assign bus.rf_waddr = waddr_q;
   assign bus.rf_wdata = wdata_q;
   assign bus.mem_err  = err_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed-vector bench for wb_stage (default build plus a NUM_SRC=3 build)
module tb_wb_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   wb_if #(.WIDTH(16), .NUM_SRC(4), .REG_ADDR_W(3)) bus ();
   wb_if #(.WIDTH(16), .NUM_SRC(3), .REG_ADDR_W(3)) bus3 ();
   wb_stage u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
   wb_stage #(.NUM_SRC(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_load(input logic [2:0] rd, input logic [1:0] mode, input logic [15:0] rdata, input int waits);
      bus.wb_valid  = 1'b1;
      bus.wb_sel    = 2'd1;
      bus.wb_rd     = rd;
      bus.load_mode = mode;
      step();
      bus.wb_valid  = 1'b0;
      check("ld_busy", bus.wb_ready, 0);
      repeat (waits) step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      step();
      bus.mem_rvalid = 1'b0;
   endtask
   logic [1:0]  b2b_sel [3] = '{2'd0, 2'd2, 2'd3};
   logic [15:0] b2b_exp [3] = '{16'h1000, 16'hBBBB, 16'hDDDD};
   logic [15:0] ext_in  [4] = '{16'hFF80, 16'hFF80, 16'h8F7F, 16'hABCD};
   logic [1:0]  ext_md  [4] = '{2'd1, 2'd2, 2'd1, 2'd3};
   logic [15:0] ext_exp [4] = '{16'hFF80, 16'h0080, 16'h007F, 16'hABCD};
   initial begin
      int cyc;
      bit seen;
      bus.wb_valid = 0; bus.wb_sel = 0; bus.wb_rd = 0; bus.load_mode = 0;
      bus.src_data = {16'hDDDD, 16'hBBBB, 16'hCCCC, 16'h5678};
      bus.mem_rdata = 0; bus.mem_rvalid = 0;
      bus3.wb_valid = 0; bus3.wb_sel = 0; bus3.wb_rd = 0; bus3.load_mode = 0;
      bus3.src_data = {16'h3333, 16'h2222, 16'hAAAA};
      bus3.mem_rdata = 0; bus3.mem_rvalid = 0;
      repeat (2) step();
      rst = 1'b0;
      step();
      check("rst_we", bus.rf_we, 0);
      check("rst_waddr", bus.rf_waddr, 0);
      check("rst_wdata", bus.rf_wdata, 0);
      check("rst_err", bus.mem_err, 0);
      check("rst_ready", bus.wb_ready, 1);
      bus.wb_valid = 1; bus.wb_sel = 0; bus.wb_rd = 3;
      step();
      check("alu_we", bus.rf_we, 1);
      check("alu_waddr", bus.rf_waddr, 3);
      check("alu_wdata", bus.rf_wdata, 16'h5678);
      bus.src_data[15:0] = 16'h1000;
      for (int i = 0; i < 3; i++) begin
         bus.wb_sel = b2b_sel[i];
         bus.wb_rd  = 3'(4 + i);
         check("b2b_ready", bus.wb_ready, 1);
         step();
         check("b2b_we", bus.rf_we, 1);
         check("b2b_waddr", bus.rf_waddr, 4 + i);
         check("b2b_wdata", bus.rf_wdata, b2b_exp[i]);
      end
      bus.wb_valid = 0;
      bus.mem_rvalid = 1; bus.mem_rdata = 16'h9999;
      step();
      bus.mem_rvalid = 0;
      check("idle_rvalid_we", bus.rf_we, 0);
      check("idle_rvalid_ready", bus.wb_ready, 1);
      bus.wb_valid = 1; bus.wb_sel = 1; bus.wb_rd = 2; bus.load_mode = 0;
      step();
      bus.wb_valid = 0;
      for (int i = 0; i < 4; i++) begin
         check("ldw_ready", bus.wb_ready, 0);
         check("ldw_we", bus.rf_we, 0);
         if (i < 3) step();
      end
      bus.mem_rvalid = 1; bus.mem_rdata = 16'h1234;
      step();
      bus.mem_rvalid = 0;
      check("ldw_we1", bus.rf_we, 1);
      check("ldw_waddr", bus.rf_waddr, 2);
      check("ldw_wdata", bus.rf_wdata, 16'h1234);
      check("ldw_ready1", bus.wb_ready, 1);
      for (int i = 0; i < 4; i++) begin
         do_load(3'(1 + i), ext_md[i], ext_in[i], i);
         check("ext_we", bus.rf_we, 1);
         check("ext_wdata", bus.rf_wdata, ext_exp[i]);
      end
      bus.wb_valid = 1; bus.wb_sel = 1; bus.wb_rd = 5; bus.load_mode = 0;
      step();
      bus.wb_valid = 0;
      cyc = 0; seen = 0;
      while (!seen && cyc < 40) begin
         step();
         cyc++;
         if (bus.rf_we) check("to_we", bus.rf_we, 0);
         seen = bus.mem_err;
      end
      check("to_seen", seen, 1);
      check("to_cycles", cyc, 16);
      check("to_ready", bus.wb_ready, 1);
      step();
      check("to_pulse", bus.mem_err, 0);
      bus.wb_valid = 1; bus.wb_sel = 1; bus.wb_rd = 6; bus.load_mode = 0;
      step();
      bus.wb_valid = 0;
      repeat (15) step();
      check("late_err", bus.mem_err, 0);
      check("late_ready", bus.wb_ready, 0);
      bus.mem_rvalid = 1; bus.mem_rdata = 16'h4321;
      step();
      bus.mem_rvalid = 0;
      check("late_we", bus.rf_we, 1);
      check("late_err2", bus.mem_err, 0);
      check("late_wdata", bus.rf_wdata, 16'h4321);
      bus.src_data[15:0] = 16'hFFFF;
      bus.wb_valid = 1; bus.wb_sel = 0; bus.wb_rd = 0;
      step();
      bus.wb_valid = 0;
      check("zr_we", bus.rf_we, 0);
      check("zr_ready", bus.wb_ready, 1);
      do_load(3'd0, 2'd0, 16'h7777, 2);
      check("zr_ld_we", bus.rf_we, 0);
      check("zr_ld_ready", bus.wb_ready, 1);
      bus3.wb_valid = 1; bus3.wb_sel = 3; bus3.wb_rd = 6;
      step();
      check("oor_we", bus3.rf_we, 1);
      check("oor_waddr", bus3.rf_waddr, 6);
      check("oor_wdata", bus3.rf_wdata, 16'hAAAA);
      bus3.wb_sel = 2;
      step();
      bus3.wb_valid = 0;
      check("sel2_wdata", bus3.rf_wdata, 16'h3333);
      bus.wb_valid = 1; bus.wb_sel = 1; bus.wb_rd = 4;
      step();
      bus.wb_valid = 0;
      step();
      check("rml_busy", bus.wb_ready, 0);
      rst = 1'b1;
      #1;
      check("rml_async_ready", bus.wb_ready, 1);
      step();
      rst = 1'b0;
      bus.mem_rvalid = 1; bus.mem_rdata = 16'h5555;
      step();
      bus.mem_rvalid = 0;
      check("rml_we", bus.rf_we, 0);
      check("rml_err", bus.mem_err, 0);
      check("rml_wdata", bus.rf_wdata, 0);
      check("rml_ready", bus.wb_ready, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
